// File: rtl/vco_dac_spi_tx.sv
// vco_dac_spi_tx -- SPI write serializer for the VCO tuning DAC.
//
// Takes 13-bit control-voltage words from the ramp controller, prefixes a
// 3-bit DAC command and shifts the frame out MSB first in SPI mode 0.
// Words that arrive while a frame is on the wire are coalesced into a
// single pending slot (newest wins), so the upstream side never stalls.
//
// Build option: define VCO_DAC_LDAC_EN to add the ldacn latch strobe
// (2-cycle low pulse after csn rises, inter-frame gap stretched to >= 3).
//
// Ports:
//   clk    in   system clock
//   arstn  in   asynchronous active-low reset
//   wdat   in   [DATA_W] voltage word, sampled when load=1
//   load   in   single-cycle write request
//   busy   out  frame active or a word pending
//   done   out  one-cycle pulse when a frame completes (csn rise)
//   sck    out  SPI clock, idles low
//   mosi   out  SPI data
//   csn    out  SPI chip select, active low
//   ldacn  out  DAC latch strobe, active low (VCO_DAC_LDAC_EN only)
module vco_dac_spi_tx #(
  parameter int               DATA_W   = 13,
  parameter int               CMD_W    = 3,
  parameter logic [CMD_W-1:0] CMD      = 3'b011,
  parameter int               CLK_DIV  = 4,
  parameter int               CS_SETUP = 2,
  parameter int               CS_HOLD  = 2,
  parameter int               CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [DATA_W-1:0] wdat,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic              csn
`ifdef VCO_DAC_LDAC_EN
  ,
  output logic              ldacn
`endif
);

  localparam int FRAME_W = CMD_W + DATA_W;
`ifdef VCO_DAC_LDAC_EN
  // Gap must cover the 2-cycle ldacn pulse plus one cycle of it being high.
  localparam int GAP_LEN = (CS_IDLE > 3) ? CS_IDLE : 3;
`else
  localparam int GAP_LEN = CS_IDLE;
`endif
  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > GAP_LEN) ? CS_HOLD : GAP_LEN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  // Counters load "length-1" and count down to zero.
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO   = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  // Bits still to be sent after the one currently on mosi.
  logic [FRAME_W-2:0]   r_rest, w_rest_nxt;
  logic                 r_pend, w_pend_nxt;
  logic [DATA_W-1:0]    r_pdat, w_pdat_nxt;
  logic                 r_csn, w_csn_nxt;
  logic                 r_sck, w_sck_nxt;
  logic                 r_mosi, w_mosi_nxt;
  logic                 r_done, w_done_nxt;
  logic [DATA_W-1:0]    w_word;
  logic [FRAME_W-1:0]   w_frame;

  // A fresh load always beats an older pending word.
  assign w_word  = load ? wdat : r_pdat;
  assign w_frame = {CMD, w_word};

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_rest_nxt  = r_rest;
    w_pend_nxt  = r_pend;
    w_pdat_nxt  = r_pdat;
    w_csn_nxt   = r_csn;
    w_sck_nxt   = r_sck;
    w_mosi_nxt  = r_mosi;
    w_done_nxt  = 1'b0;

    // Any load outside IDLE (including the done cycle) lands in the pending slot.
    if (load && (r_state != S_IDLE)) begin
      w_pend_nxt = 1'b1;
      w_pdat_nxt = wdat;
    end else begin
      w_pend_nxt = r_pend;
      w_pdat_nxt = r_pdat;
    end

    case (r_state)
      S_IDLE: begin
        if (load || r_pend) begin
          w_rest_nxt  = w_frame[FRAME_W-2:0];
          w_mosi_nxt  = w_frame[FRAME_W-1];
          w_pend_nxt  = 1'b0;
          w_csn_nxt   = 1'b0;
          w_cnt_nxt   = SETUP_LAST;
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_ZERO) begin
          w_cnt_nxt   = DIV_LAST;
          w_bit_nxt   = BIT_TOP;
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (!r_sck) begin
          w_sck_nxt = 1'b1;
          w_cnt_nxt = DIV_LAST;
        end else if (r_bit == BIT_ZERO) begin
          w_sck_nxt   = 1'b0;
          w_cnt_nxt   = HOLD_LAST;
          w_state_nxt = S_HOLD;
        end else begin
          // Falling sck: present the next bit for the following rising edge.
          w_sck_nxt  = 1'b0;
          w_cnt_nxt  = DIV_LAST;
          w_bit_nxt  = r_bit - BIT_ONE;
          w_mosi_nxt = r_rest[FRAME_W-2];
          w_rest_nxt = {r_rest[FRAME_W-3:0], 1'b0};
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_ZERO) begin
          w_csn_nxt   = 1'b1;
          w_mosi_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = GAP_LAST;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_csn_nxt   = 1'b1;
        w_sck_nxt   = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered SPI outputs.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt  <= CNT_ZERO;
      r_bit  <= BIT_ZERO;
      r_rest <= '0;
      r_pend <= 1'b0;
      r_pdat <= '0;
      r_csn  <= 1'b1;
      r_sck  <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_bit  <= w_bit_nxt;
      r_rest <= w_rest_nxt;
      r_pend <= w_pend_nxt;
      r_pdat <= w_pdat_nxt;
      r_csn  <= w_csn_nxt;
      r_sck  <= w_sck_nxt;
      r_mosi <= w_mosi_nxt;
      r_done <= w_done_nxt;
    end
  end

`ifdef VCO_DAC_LDAC_EN
  logic r_ldacn;
  logic w_ldacn_nxt;
  // Low during the first two GAP counter values, i.e. csn_rise+1 and +2.
  localparam logic [CNT_W-1:0] LDAC_LO = CNT_W'(GAP_LEN - 2);

  assign w_ldacn_nxt = !((r_state == S_GAP) && (r_cnt >= LDAC_LO));

  // DAC latch strobe register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_ldacn <= 1'b1;
    end else begin
      r_ldacn <= w_ldacn_nxt;
    end
  end

  assign ldacn = r_ldacn;
`endif

  // Derived only from registers, so load cannot glitch it.
  assign busy = (r_state != S_IDLE) || r_pend;
  assign done = r_done;
  assign sck  = r_sck;
  assign mosi = r_mosi;
  assign csn  = r_csn;

endmodule

// File: tb/tb_vco_dac_spi_tx.sv
// Testbench for vco_dac_spi_tx: a default-parameter instance and a
// fast instance (CLK_DIV=1, all CS timings 1). A bus monitor rebuilds
// frames from mosi on sck rising edges and timestamps csn/done/busy;
// expected frames, lengths and gaps come from the framing rules.
module tb_vco_dac_spi_tx;

`ifdef VCO_DAC_LDAC_EN
  localparam int GAP0 = 3;
  localparam int GAP1 = 3;
`else
  localparam int GAP0 = 2;
  localparam int GAP1 = 1;
`endif
  localparam int LEN0 = 2 + 2 * 4 * 16 + 2;
  localparam int LEN1 = 1 + 2 * 1 * 16 + 1;

  logic clk = 1'b0;
  logic arstn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] wdat0 = 13'h0, wdat1 = 13'h0;
  logic load0 = 1'b0, load1 = 1'b0;
  logic busy0, done0, sck0, mosi0, csn0;
  logic busy1, done1, sck1, mosi1, csn1;
`ifdef VCO_DAC_LDAC_EN
  logic ldacn0, ldacn1;
`endif

  vco_dac_spi_tx dut0 (
    .clk(clk), .arstn(arstn), .wdat(wdat0), .load(load0), .busy(busy0),
    .done(done0), .sck(sck0), .mosi(mosi0), .csn(csn0)
`ifdef VCO_DAC_LDAC_EN
    , .ldacn(ldacn0)
`endif
  );

  vco_dac_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut1 (
    .clk(clk), .arstn(arstn), .wdat(wdat1), .load(load1), .busy(busy1),
    .done(done1), .sck(sck1), .mosi(mosi1), .csn(csn1)
`ifdef VCO_DAC_LDAC_EN
    , .ldacn(ldacn1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] frm(input logic [12:0] w);
    return {3'b011, w};
  endfunction

  // ---------------- bus monitor ----------------
  logic        m_csn[2], m_sck[2], m_mosi[2], m_done[2], m_busy[2];
  assign m_csn[0] = csn0;   assign m_csn[1] = csn1;
  assign m_sck[0] = sck0;   assign m_sck[1] = sck1;
  assign m_mosi[0] = mosi0; assign m_mosi[1] = mosi1;
  assign m_done[0] = done0; assign m_done[1] = done1;
  assign m_busy[0] = busy0; assign m_busy[1] = busy1;

  logic [15:0] cap_frame[2][8];
  int          cap_len[2][8], cap_rises[2][8], cap_fall[2][8], cap_rise[2][8];
  int          cap_n[2], n_done[2], done_cyc[2], busy_fall[2], stray[2], badsp[2];
  logic [15:0] cur_bits[2];
  int          cur_fall[2], cur_nrise[2], last_rise[2];
  logic        p_csn[2], p_sck[2], p_busy[2];
  logic [3:0]  ld_pat;
  int          spacing[2];

  task automatic clr(input int k);
    cap_n[k] = 0; n_done[k] = 0; stray[k] = 0; badsp[k] = 0;
    done_cyc[k] = -1; busy_fall[k] = -1;
  endtask

  initial begin
    spacing[0] = 8; spacing[1] = 2;
    ld_pat = 4'h0;
    for (int k = 0; k < 2; k++) begin
      p_csn[k] = 1'b1; p_sck[k] = 1'b0; p_busy[k] = 1'b0;
      cur_bits[k] = 16'h0; cur_fall[k] = 0; cur_nrise[k] = 0; last_rise[k] = 0;
      clr(k);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (p_csn[k] && !m_csn[k]) begin
          cur_fall[k] = cyc; cur_nrise[k] = 0; cur_bits[k] = 16'h0;
        end
        if (!p_sck[k] && m_sck[k]) begin
          if (m_csn[k]) stray[k]++;
          if (cur_nrise[k] != 0 && (cyc - last_rise[k]) != spacing[k]) badsp[k]++;
          last_rise[k] = cyc;
          cur_bits[k] = {cur_bits[k][14:0], m_mosi[k]};
          cur_nrise[k]++;
        end
        if (!p_csn[k] && m_csn[k] && cap_n[k] < 8) begin
          cap_frame[k][cap_n[k]] = cur_bits[k];
          cap_len[k][cap_n[k]]   = cyc - cur_fall[k];
          cap_rises[k][cap_n[k]] = cur_nrise[k];
          cap_fall[k][cap_n[k]]  = cur_fall[k];
          cap_rise[k][cap_n[k]]  = cyc;
          cap_n[k]++;
        end
        if (m_done[k]) begin
          n_done[k]++; done_cyc[k] = cyc;
        end
        if (p_busy[k] && !m_busy[k]) busy_fall[k] = cyc;
        p_csn[k] = m_csn[k]; p_sck[k] = m_sck[k]; p_busy[k] = m_busy[k];
      end
`ifdef VCO_DAC_LDAC_EN
      if (cap_n[0] > 0) begin
        int d;
        d = cyc - cap_rise[0][cap_n[0]-1];
        if (d >= 0 && d <= 3) ld_pat[d[1:0]] = ldacn0;
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_w(input int k, input logic [12:0] w);
    @(posedge clk); #1;
    if (k == 0) begin wdat0 = w; load0 = 1'b1; end
    else begin wdat1 = w; load1 = 1'b1; end
    @(posedge clk); #1;
    load0 = 1'b0; load1 = 1'b0;
  endtask

  task automatic wait_done(input int k, input int nfr, input string tag);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (cap_n[k] >= nfr && !m_busy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    chk({tag, "_complete"}, {31'h0, ok}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [12:0] a, b, c;
    logic        ok;

    #3 arstn = 1'b0;
    #1;
    chk("rst_csn", {31'h0, csn0}, 32'h1);
    chk("rst_sck", {31'h0, sck0}, 32'h0);
    chk("rst_mosi", {31'h0, mosi0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_done", {31'h0, done0}, 32'h0);
    chk("rst_csn1", {31'h0, csn1}, 32'h1);
`ifdef VCO_DAC_LDAC_EN
    chk("rst_ldacn", {31'h0, ldacn0}, 32'h1);
`endif
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;

    // Single write with defaults
    clr(0);
    load_w(0, 13'h1A5C);
    wait_done(0, 1, "single");
    chk("single_nframes", cap_n[0], 1);
    chk("single_frame", {16'h0, cap_frame[0][0]}, 32'h7A5C);
    chk("single_csn_len", cap_len[0][0], LEN0);
    chk("single_rises", cap_rises[0][0], 16);
    chk("single_spacing", badsp[0], 0);
    chk("single_stray", stray[0], 0);
    chk("single_ndone", n_done[0], 1);
    chk("single_done_at_rise", done_cyc[0], cap_rise[0][0]);
    chk("single_busy_fall", busy_fall[0] - done_cyc[0], GAP0);
`ifdef VCO_DAC_LDAC_EN
    chk("ldacn_pattern", {28'h0, ld_pat}, 32'h9);
`endif

    // Random single writes
    for (int i = 0; i < 3; i++) begin
      a = 13'($urandom);
      clr(0);
      load_w(0, a);
      wait_done(0, 1, "rand_single");
      chk("rand_single_frame", {16'h0, cap_frame[0][0]}, {16'h0, frm(a)});
      chk("rand_single_len", cap_len[0][0], LEN0);
    end

    // Coalescing, directed
    clr(0);
    load_w(0, 13'h0001);
    repeat (20) @(posedge clk);
    load_w(0, 13'h0002);
    repeat (10) @(posedge clk);
    load_w(0, 13'h0003);
    wait_done(0, 2, "coal");
    chk("coal_nframes", cap_n[0], 2);
    chk("coal_frame0", {16'h0, cap_frame[0][0]}, 32'h6001);
    chk("coal_frame1", {16'h0, cap_frame[0][1]}, 32'h6003);
    chk("coal_gap", cap_fall[0][1] - cap_rise[0][0], GAP0 + 1);
    chk("coal_ndone", n_done[0], 2);

    // Coalescing, randomized: first word then newest of the in-flight loads
    for (int i = 0; i < 2; i++) begin
      a = 13'($urandom); b = 13'($urandom); c = 13'($urandom);
      clr(0);
      load_w(0, a);
      repeat ($urandom_range(60, 5)) @(posedge clk);
      load_w(0, b);
      repeat ($urandom_range(40, 1)) @(posedge clk);
      load_w(0, c);
      wait_done(0, 2, "rcoal");
      chk("rcoal_nframes", cap_n[0], 2);
      chk("rcoal_frame0", {16'h0, cap_frame[0][0]}, {16'h0, frm(a)});
      chk("rcoal_frame1", {16'h0, cap_frame[0][1]}, {16'h0, frm(c)});
    end

    // Load on the done cycle
    a = 13'($urandom);
    clr(0);
    load_w(0, a);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (done0) begin ok = 1'b1; break; end
    end
    chk("donecyc_seen", {31'h0, ok}, 32'h1);
    wdat0 = 13'h1FFF; load0 = 1'b1;
    @(posedge clk); #1 load0 = 1'b0;
    wait_done(0, 2, "donecyc");
    chk("donecyc_nframes", cap_n[0], 2);
    chk("donecyc_frame0", {16'h0, cap_frame[0][0]}, {16'h0, frm(a)});
    chk("donecyc_frame1", {16'h0, cap_frame[0][1]}, 32'h7FFF);
    chk("donecyc_gap", cap_fall[0][1] - cap_rise[0][0], GAP0 + 1);

    // Reset during bit 7 of SHIFT
    clr(0);
    load_w(0, 13'($urandom));
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      if (cur_nrise[0] == 9 && sck0) begin ok = 1'b1; break; end
    end
    chk("rstmid_reached_bit7", {31'h0, ok}, 32'h1);
    repeat (2) @(posedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("rstmid_csn", {31'h0, csn0}, 32'h1);
    chk("rstmid_sck", {31'h0, sck0}, 32'h0);
    chk("rstmid_mosi", {31'h0, mosi0}, 32'h0);
    chk("rstmid_busy", {31'h0, busy0}, 32'h0);
    #3 arstn = 1'b1;
    clr(0);
    repeat (300) @(posedge clk);
    #1;
    chk("rstmid_no_frame", cap_n[0], 0);
    chk("rstmid_no_done", n_done[0], 0);
    chk("rstmid_idle_busy", {31'h0, busy0}, 32'h0);
    a = 13'($urandom);
    load_w(0, a);
    wait_done(0, 1, "rstmid_after");
    chk("rstmid_after_frame", {16'h0, cap_frame[0][0]}, {16'h0, frm(a)});

    // Fast instance: CLK_DIV=1, all CS timings 1
    clr(1);
    load_w(1, 13'h0AAA);
    wait_done(1, 1, "fast");
    chk("fast_frame", {16'h0, cap_frame[1][0]}, 32'h6AAA);
    chk("fast_csn_len", cap_len[1][0], LEN1);
    chk("fast_rises", cap_rises[1][0], 16);
    chk("fast_spacing", badsp[1], 0);
    a = 13'($urandom); b = 13'($urandom);
    clr(1);
    load_w(1, a);
    repeat (5) @(posedge clk);
    load_w(1, b);
    wait_done(1, 2, "fast_coal");
    chk("fast_coal_frame0", {16'h0, cap_frame[1][0]}, {16'h0, frm(a)});
    chk("fast_coal_frame1", {16'h0, cap_frame[1][1]}, {16'h0, frm(b)});
    chk("fast_coal_gap", cap_fall[1][1] - cap_rise[1][0], GAP1 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
